// File: rtl/friscv_pkg.sv
// Shared core definitions: architecture width and
// the instruction-memory loader state encoding.
package friscv_pkg;

  localparam int ARCH = 32;

  typedef enum logic [2:0] {
    LEN,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Little-endian 4-byte assembly register with byte counter.
// word_out is the completed word while full_out is high.
module byte_assembler
  import friscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_in,
  input  logic            en_in,
  input  logic [7:0]      byte_in,
  output logic [ARCH-1:0] word_out,
  output logic            full_out
);

  logic [ARCH-1:0] word_q, word_d;
  logic [1:0]      cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_in) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (en_in) begin
      word_d = {byte_in, word_q[ARCH-1:8]};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  // First byte shifts down to bits 7:0 by the fourth byte.
  assign word_out = {byte_in, word_q[ARCH-1:8]};
  assign full_out = en_in && !clr_in && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream into imem port A,
// holding the CPU core in reset until the image is complete.
module imem_loader
  import friscv_pkg::*;
#(
  parameter int IMEM_DEPTH = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      byte_in,
  input  logic            byte_valid_in,
  output logic            byte_ready_out,
  input  logic            start_in,
  output logic [ARCH-1:0] imem_addr_out,
  output logic [ARCH-1:0] imem_din_out,
  output logic            imem_we_out,
  output logic            cpu_rst_n_out,
  output logic            busy_out,
  output logic            done_out,
  output logic            err_out
);

  localparam int IDX_W = $clog2(IMEM_DEPTH) + 1;

  loader_state_t state_q, state_d;
  logic [31:0]      len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ARCH-1:0]  addr_q, addr_d;
  logic [ARCH-1:0]  din_q, din_d;
  logic ready_q, ready_d;
  logic we_q, we_d;
  logic cpu_q, cpu_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic            accept;
  logic            restart;
  logic            last;
  logic [ARCH-1:0] asm_word;
  logic            asm_full;

  assign accept  = byte_valid_in && ready_q;
  assign restart = start_in &&
                   (state_q == DONE || state_q == ERR);
  assign last    = (32'(idx_q) == len_q - 32'd1);

  byte_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_in   (restart),
    .en_in    (accept),
    .byte_in  (byte_in),
    .word_out (asm_word),
    .full_out (asm_full)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    din_d   = din_q;
    unique case (state_q)
      LEN: begin
        if (asm_full) begin
          len_d = asm_word;
          if (asm_word == 32'd0)
            state_d = DONE;
          else if (asm_word > 32'(IMEM_DEPTH))
            state_d = ERR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (asm_full) begin
          state_d = WRITE;
          din_d   = asm_word;
          addr_d  = ARCH'({idx_q, 2'b00});
        end
      end
      WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = last ? DONE : DATA;
      end
      DONE, ERR: begin
        if (start_in) begin
          state_d = LEN;
          len_d   = '0;
          idx_d   = '0;
        end
      end
      default: state_d = LEN;
    endcase
  end

  // Outputs decode the next state so every port is a flop.
  always_comb begin
    ready_d = (state_d == LEN) || (state_d == DATA);
    we_d    = (state_d == WRITE);
    busy_d  = (state_d == LEN) || (state_d == DATA) ||
              (state_d == WRITE);
    cpu_d   = (state_d == DONE);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LEN;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      cpu_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      cpu_q   <= cpu_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign byte_ready_out = ready_q;
  assign imem_we_out    = we_q;
  assign imem_addr_out  = addr_q;
  assign imem_din_out   = din_q;
  assign cpu_rst_n_out  = cpu_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write log from a negedge
// monitor, every expected value written out by hand.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid_in = 1'b0;
  logic        byte_ready_out;
  logic        start_in = 1'b0;
  logic [31:0] imem_addr_out;
  logic [31:0] imem_din_out;
  logic        imem_we_out;
  logic        cpu_rst_n_out;
  logic        busy_out;
  logic        done_out;
  logic        err_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_din[$];
  logic        chk_rdy = 1'b0;

  imem_loader #(.IMEM_DEPTH(4096)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .byte_in        (byte_in),
    .byte_valid_in  (byte_valid_in),
    .byte_ready_out (byte_ready_out),
    .start_in       (start_in),
    .imem_addr_out  (imem_addr_out),
    .imem_din_out   (imem_din_out),
    .imem_we_out    (imem_we_out),
    .cpu_rst_n_out  (cpu_rst_n_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .err_out        (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && imem_we_out) begin
      wq_addr.push_back(imem_addr_out);
      wq_din.push_back(imem_din_out);
    end
    if (chk_rdy)
      check("ready_vs_we", 32'(byte_ready_out),
            32'(!imem_we_out));
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    byte_in = b;
    byte_valid_in = 1'b1;
    while (!byte_ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(byte_ready_out), 32'd1);
    check({tag, "_we"},    32'(imem_we_out),    32'd0);
    check({tag, "_addr"},  imem_addr_out,       32'd0);
    check({tag, "_din"},   imem_din_out,        32'd0);
    check({tag, "_cpu"},   32'(cpu_rst_n_out),  32'd0);
    check({tag, "_busy"},  32'(busy_out),       32'd1);
    check({tag, "_done"},  32'(done_out),       32'd0);
    check({tag, "_err"},   32'(err_out),        32'd0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done_out), 32'd1);
  endtask

  task automatic pulse_start(input logic [7:0] b,
                             input logic v);
    @(negedge clk);
    start_in = 1'b1;
    byte_in = b;
    byte_valid_in = v;
    @(negedge clk);
    start_in = 1'b0;
    byte_valid_in = 1'b0;
  endtask

  initial begin
    int bad;
    logic [31:0] exp3 [3];
    exp3[0] = 32'h00500093;
    exp3[1] = 32'h00A00113;
    exp3[2] = 32'h002081B3;

    // Reset values
    #23;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single-word image
    send_word(32'd1);
    send_word(32'h00000013);
    @(negedge clk);
    byte_valid_in = 1'b0;
    check("t1_we",    32'(imem_we_out),    32'd1);
    check("t1_addr",  imem_addr_out,       32'h0);
    check("t1_din",   imem_din_out,        32'h13);
    check("t1_ready", 32'(byte_ready_out), 32'd0);
    @(negedge clk);
    check("t1_done",  32'(done_out),       32'd1);
    check("t1_cpu",   32'(cpu_rst_n_out),  32'd1);
    check("t1_busy",  32'(busy_out),       32'd0);
    check("t1_ready2", 32'(byte_ready_out), 32'd0);
    check("t1_we2",   32'(imem_we_out),    32'd0);
    check("t1_nwr",   32'(wq_addr.size()), 32'd1);

    // Restart from DONE with a byte offered alongside start
    wq_addr.delete();
    wq_din.delete();
    pulse_start(8'h03, 1'b1);
    check("rs_cpu",   32'(cpu_rst_n_out),  32'd0);
    check("rs_busy",  32'(busy_out),       32'd1);
    check("rs_ready", 32'(byte_ready_out), 32'd1);
    check("rs_done",  32'(done_out),       32'd0);

    // N=3 with valid held high through WRITE cycles
    send_word(32'd3);
    chk_rdy = 1'b1;
    for (int i = 0; i < 3; i++) send_word(exp3[i]);
    @(negedge clk);
    byte_valid_in = 1'b0;
    check("t2_last_we", 32'(imem_we_out), 32'd1);
    #1 chk_rdy = 1'b0;
    @(negedge clk);
    wait_done("t2");
    check("t2_nwr", 32'(wq_addr.size()), 32'd3);
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      check($sformatf("t2_addr%0d", i), wq_addr[i], 32'(i * 4));
      check($sformatf("t2_din%0d", i), wq_din[i], exp3[i]);
    end

    // Zero-length image
    wq_addr.delete();
    wq_din.delete();
    pulse_start(8'h00, 1'b0);
    send_word(32'd0);
    @(negedge clk);
    byte_valid_in = 1'b0;
    check("t3_done", 32'(done_out), 32'd1);
    check("t3_cpu",  32'(cpu_rst_n_out), 32'd1);
    check("t3_nwr",  32'(wq_addr.size()), 32'd0);

    // Oversized length goes to ERR
    pulse_start(8'h00, 1'b0);
    send_word(32'h00001001);
    @(negedge clk);
    byte_valid_in = 1'b0;
    check("t4_err",   32'(err_out),        32'd1);
    check("t4_cpu",   32'(cpu_rst_n_out),  32'd0);
    check("t4_ready", 32'(byte_ready_out), 32'd0);
    check("t4_busy",  32'(busy_out),       32'd0);
    check("t4_done",  32'(done_out),       32'd0);
    pulse_start(8'h00, 1'b0);
    check("t4_rs_err", 32'(err_out), 32'd0);
    send_word(32'd1);
    send_word(32'hCAFEF00D);
    @(negedge clk);
    byte_valid_in = 1'b0;
    wait_done("t4");
    check("t4_nwr", 32'(wq_addr.size()), 32'd1);
    if (wq_din.size() > 0)
      check("t4_din", wq_din[0], 32'hCAFEF00D);

    // Full-depth image: last address 0x3FFC, no wrap
    wq_addr.delete();
    wq_din.delete();
    pulse_start(8'h00, 1'b0);
    send_word(32'd4096);
    check("t5_err", 32'(err_out), 32'd0);
    for (int i = 0; i < 4096; i++)
      send_word({i[15:0], 16'hA5C3});
    @(negedge clk);
    byte_valid_in = 1'b0;
    wait_done("t5");
    check("t5_nwr", 32'(wq_addr.size()), 32'd4096);
    bad = 0;
    for (int i = 0; i < wq_addr.size(); i++)
      if (wq_addr[i] !== 32'(i * 4) ||
          wq_din[i] !== {i[15:0], 16'hA5C3})
        bad++;
    check("t5_map", 32'(bad), 32'd0);
    check("t5_last", imem_addr_out, 32'h3FFC);

    // Asynchronous reset in the middle of word 1
    wq_addr.delete();
    wq_din.delete();
    pulse_start(8'h00, 1'b0);
    send_word(32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    #2;
    rst_n = 1'b0;
    byte_valid_in = 1'b0;
    #1;
    check_reset("mid");
    @(negedge clk);
    rst_n = 1'b1;
    send_word(32'd1);
    send_word(32'hDDCCBBAA);
    @(negedge clk);
    byte_valid_in = 1'b0;
    wait_done("t6");
    check("t6_nwr", 32'(wq_addr.size()), 32'd1);
    if (wq_addr.size() > 0) begin
      check("t6_addr", wq_addr[0], 32'h0);
      check("t6_din",  wq_din[0],  32'hDDCCBBAA);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
